// File: rtl/hazard_scoreboard.sv
// Pipeline hazard/stall controller: load-use scoreboard, MDU busy interlock,
// branch/jump flush priority and a saturating stall-cycle counter.
module hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int MDU_LAT  = 32,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_is_load,
   input  logic              id_is_mdu,
   input  logic              id_reads_hilo,
   input  logic              id_is_jump,
   input  logic              ex_branch_taken,
   output logic              pc_wr_en,
   output logic              if_id_wr_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              mdu_busy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [7:0] MDU_INIT = 8'(MDU_LAT);

   logic [LOAD_LAT-1:0] sb_valid;
   logic [REG_AW-1:0]   sb_rd [LOAD_LAT];
   logic [7:0]          mdu_cnt;
   logic                mdu_active;
   logic                load_use;
   logic                mdu_stall;
   logic                stall;
   logic                advance;

   // Entry 0 tracks the instruction now in EX; register 0 is never a hazard.
   always_comb begin
      load_use = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         if (sb_valid[k] && (sb_rd[k] != '0) &&
             ((id_rs_used && (sb_rd[k] == id_rs)) ||
              (id_rt_used && (sb_rd[k] == id_rt))))
            load_use = 1'b1;
      end
   end

   assign mdu_active = (mdu_cnt != 8'd0);
   assign mdu_stall  = mdu_active && (id_is_mdu || id_reads_hilo);
   assign stall      = (load_use || mdu_stall) && !ex_branch_taken;
   assign advance    = !stall && !ex_branch_taken;
   assign mdu_busy   = rst_n && mdu_active;

   // Branch beats stall beats jump; reset forces the idle pattern.
   always_comb begin
      pc_wr_en    = 1'b1;
      if_id_wr_en = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (rst_n) begin
         if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (stall) begin
            pc_wr_en    = 1'b0;
            if_id_wr_en = 1'b0;
            id_ex_flush = 1'b1;
         end else if (id_is_jump) begin
            if_id_flush = 1'b1;
         end
      end
   end

   // Scoreboard shifts every cycle; stalled or squashed ID slots enter as bubbles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_valid <= '0;
         for (int k = 0; k < LOAD_LAT; k++)
            sb_rd[k] <= '0;
      end else begin
         for (int k = LOAD_LAT - 1; k > 0; k--) begin
            sb_valid[k] <= sb_valid[k-1];
            sb_rd[k]    <= sb_rd[k-1];
         end
         sb_valid[0] <= advance && id_is_load && (id_rd != '0);
         sb_rd[0]    <= advance ? id_rd : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         mdu_cnt <= 8'd0;
      else if (advance && id_is_mdu)
         mdu_cnt <= MDU_INIT;
      else if (mdu_active)
         mdu_cnt <= mdu_cnt - 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vectors for hazard_scoreboard (LOAD_LAT=3, MDU_LAT=4, CNT_W=4);
// expected outputs are queued per cycle and checked by a separate monitor.
module tb_hazard_scoreboard;

   localparam logic [3:0] IDLE = 4'b1100;
   localparam logic [3:0] STL  = 4'b0001;
   localparam logic [3:0] BRF  = 4'b1111;
   localparam logic [3:0] JMP  = 4'b1110;

   typedef struct {
      string      tag;
      logic [3:0] ctl;
      logic       busy;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_rs_used, id_rt_used;
   logic       id_is_load, id_is_mdu, id_reads_hilo, id_is_jump;
   logic       ex_branch_taken;
   logic       pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush, mdu_busy;
   logic [3:0] stall_cnt;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   hazard_scoreboard #(
      .REG_AW(5), .LOAD_LAT(3), .MDU_LAT(4), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rd(id_rd), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
      .id_reads_hilo(id_reads_hilo), .id_is_jump(id_is_jump),
      .ex_branch_taken(ex_branch_taken),
      .pc_wr_en(pc_wr_en), .if_id_wr_en(if_id_wr_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Drives one cycle of inputs just after the rising edge and queues its expectation.
   task automatic applyStimulus(input string tag, input logic r,
                                input logic [4:0] rs, input logic rs_u,
                                input logic [4:0] rt, input logic rt_u,
                                input logic [4:0] rd, input logic ld,
                                input logic mdu, input logic hilo,
                                input logic jmp, input logic br,
                                input logic [3:0] ctl, input logic busy,
                                input logic [3:0] cnt);
      exp_t e;
      rst_n = r;
      id_rs = rs; id_rs_used = rs_u;
      id_rt = rt; id_rt_used = rt_u;
      id_rd = rd; id_is_load = ld;
      id_is_mdu = mdu; id_reads_hilo = hilo;
      id_is_jump = jmp; ex_branch_taken = br;
      e.tag = tag; e.ctl = ctl; e.busy = busy; e.cnt = cnt;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input exp_t e);
      logic [3:0] got_ctl;
      got_ctl = {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_flush};
      n_checks++;
      if ({got_ctl, mdu_busy, stall_cnt} === {e.ctl, e.busy, e.cnt})
         n_pass++;
      else
         $display("[TB] FAIL %s: got ctl=%b busy=%b cnt=%0d, expected ctl=%b busy=%b cnt=%0d",
                  e.tag, got_ctl, mdu_busy, stall_cnt, e.ctl, e.busy, e.cnt);
   endtask

   // Monitor samples on the falling edge, mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0)
            checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      rst_n = 1'b0;
      id_rs = '0; id_rt = '0; id_rd = '0;
      id_rs_used = 1'b0; id_rt_used = 1'b0;
      id_is_load = 1'b0; id_is_mdu = 1'b0; id_reads_hilo = 1'b0;
      id_is_jump = 1'b0; ex_branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      //             tag            r  rs   u  rt   u  rd   ld md hl jp br ctl  bsy cnt
      applyStimulus("rst_force",   0, 5'd8, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 1, IDLE, 0, 4'd0);
      applyStimulus("lw8",         1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0, IDLE, 0, 4'd0);
      applyStimulus("d1_use_a",    1, 5'd8, 1, 5'd8, 1, 5'd9, 0, 0, 0, 0, 0, STL,  0, 4'd0);
      applyStimulus("d1_use_b",    1, 5'd8, 1, 5'd8, 1, 5'd9, 0, 0, 0, 0, 0, STL,  0, 4'd1);
      applyStimulus("d1_use_c",    1, 5'd8, 1, 5'd8, 1, 5'd9, 0, 0, 0, 0, 0, STL,  0, 4'd2);
      applyStimulus("d1_release",  1, 5'd8, 1, 5'd8, 1, 5'd9, 0, 0, 0, 0, 0, IDLE, 0, 4'd3);
      applyStimulus("lw8_b",       1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0, IDLE, 0, 4'd3);
      applyStimulus("nop_gap",     1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, 0, 4'd3);
      applyStimulus("d2_use_a",    1, 5'd8, 0, 5'd8, 1, 5'd3, 0, 0, 0, 0, 0, STL,  0, 4'd3);
      applyStimulus("d2_use_b",    1, 5'd8, 0, 5'd8, 1, 5'd3, 0, 0, 0, 0, 0, STL,  0, 4'd4);
      applyStimulus("d2_release",  1, 5'd8, 0, 5'd8, 1, 5'd3, 0, 0, 0, 0, 0, IDLE, 0, 4'd5);
      applyStimulus("lw7",         1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0, 0, IDLE, 0, 4'd5);
      applyStimulus("r7_unused",   1, 5'd7, 0, 5'd7, 0, 5'd4, 0, 0, 0, 0, 0, IDLE, 0, 4'd5);
      applyStimulus("lw_r0",       1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, IDLE, 0, 4'd5);
      applyStimulus("use_r0",      1, 5'd0, 1, 5'd0, 1, 5'd5, 0, 0, 0, 0, 0, IDLE, 0, 4'd5);
      applyStimulus("mult",        1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, IDLE, 0, 4'd5);
      applyStimulus("mflo_s1",     1, 5'd0, 0, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, STL,  1, 4'd5);
      applyStimulus("mflo_s2",     1, 5'd0, 0, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, STL,  1, 4'd6);
      applyStimulus("mflo_s3",     1, 5'd0, 0, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, STL,  1, 4'd7);
      applyStimulus("mflo_s4",     1, 5'd0, 0, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, STL,  1, 4'd8);
      applyStimulus("mflo_go",     1, 5'd0, 0, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, IDLE, 0, 4'd9);
      applyStimulus("mult2",       1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, IDLE, 0, 4'd9);
      applyStimulus("nop_busy",    1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, IDLE, 1, 4'd9);
      applyStimulus("mdu_on_busy", 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, STL,  1, 4'd9);
      applyStimulus("lw8_c",       1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0, IDLE, 1, 4'd10);
      applyStimulus("both_stall",  1, 5'd8, 1, 5'd0, 0, 5'd6, 0, 0, 1, 0, 0, STL,  1, 4'd10);
      applyStimulus("lu_only_a",   1, 5'd8, 1, 5'd0, 0, 5'd6, 0, 0, 1, 0, 0, STL,  0, 4'd11);
      applyStimulus("lu_only_b",   1, 5'd8, 1, 5'd0, 0, 5'd6, 0, 0, 1, 0, 0, STL,  0, 4'd12);
      applyStimulus("both_clear",  1, 5'd8, 1, 5'd0, 0, 5'd6, 0, 0, 1, 0, 0, IDLE, 0, 4'd13);
      applyStimulus("lw9",         1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 0, 0, IDLE, 0, 4'd13);
      applyStimulus("br_on_stall", 1, 5'd9, 1, 5'd0, 0, 5'd10,1, 0, 0, 0, 1, BRF,  0, 4'd13);
      applyStimulus("use_squash",  1, 5'd10,1, 5'd0, 0, 5'd2, 0, 0, 0, 0, 0, IDLE, 0, 4'd13);
      applyStimulus("br_on_mdu",   1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 1, BRF,  0, 4'd13);
      applyStimulus("hilo_no_mdu", 1, 5'd0, 0, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, IDLE, 0, 4'd13);
      applyStimulus("lw11",        1, 5'd0, 0, 5'd0, 0, 5'd11,1, 0, 0, 0, 0, IDLE, 0, 4'd13);
      applyStimulus("jr_hold_a",   1, 5'd11,1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, STL,  0, 4'd13);
      applyStimulus("jr_hold_b",   1, 5'd11,1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, STL,  0, 4'd14);
      applyStimulus("jr_hold_sat", 1, 5'd11,1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, STL,  0, 4'd15);
      applyStimulus("jr_flush",    1, 5'd11,1, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, JMP,  0, 4'd15);
      applyStimulus("lw12",        1, 5'd0, 0, 5'd0, 0, 5'd12,1, 0, 0, 0, 0, IDLE, 0, 4'd15);
      applyStimulus("mult3",       1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, IDLE, 0, 4'd15);
      applyStimulus("mflo_sat",    1, 5'd12,1, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, STL,  1, 4'd15);
      applyStimulus("rst_mid",     0, 5'd12,1, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, IDLE, 0, 4'd15);
      applyStimulus("after_rst",   1, 5'd12,1, 5'd0, 0, 5'd2, 0, 0, 1, 0, 0, IDLE, 0, 4'd0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and stall controller for the 5-stage pipeline, and the successor to the combinational load-use/jump hazard unit. It adds a configurable-latency load scoreboard, a multi-cycle MDU busy interlock with an internal countdown, a prioritised branch/jump flush and a saturating stall-cycle counter. It sits beside the IF/ID and ID/EX pipeline registers and drives their write-enable and flush controls and the PC write-enable.

## Interface
Parameters:
- REG_AW, 5: register address width.
- LOAD_LAT, 1: cycles after a load leaves ID before its data is forwardable; legal 1..4. Also the scoreboard depth.
- MDU_LAT, 32: multiply/divide occupancy in cycles; legal 1..255.
- CNT_W, 32: width of the stall counter.

Ports (decided: one clock, reset synchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID.
- id_rs_used, id_rt_used  in  1  the ID instruction actually reads rs / rt.
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_is_load  in  1  the ID instruction is a load.
- id_is_mdu  in  1  the ID instruction starts an MDU operation.
- id_reads_hilo  in  1  the ID instruction is mfhi or mflo.
- id_is_jump  in  1  the ID instruction is j, jal, jr or jalr.
- ex_branch_taken  in  1  branch resolved taken in EX.
- pc_wr_en  out  1  PC write enable.
- if_id_wr_en  out  1  IF/ID write enable.
- if_id_flush  out  1  squash IF/ID.
- id_ex_flush  out  1  insert a bubble into ID/EX.
- mdu_busy  out  1  MDU countdown is non-zero.
- stall_cnt  out  CNT_W  total stall cycles since reset.

## Operation
- **Scoreboard state.** LOAD_LAT entries, each {valid, rd}. Entry 0 corresponds to the instruction in EX. All entries shift one place every cycle, and the oldest entry falls out.
- **Scoreboard insert.** The ID instruction advances when there is no stall and ex_branch_taken=0.
  - When it advances, entry 0 takes {id_is_load && id_rd!=0, id_rd}.
  - Otherwise entry 0 takes a bubble {0, 0}.
- **load_use.** Asserted when any valid entry's rd equals id_rs with id_rs_used, or equals id_rt with id_rt_used. Register 0 never matches.
- **MDU counter.** 8 bits, named mdu_cnt.
  - Loaded with MDU_LAT when id_is_mdu and the instruction advances.
  - Otherwise decremented while non-zero.
  - mdu_busy = (mdu_cnt != 0).
- **mdu_stall.** mdu_busy && (id_is_mdu || id_reads_hilo).
- **stall.** (load_use || mdu_stall) && !ex_branch_taken.
- **Output priority, highest first:**
  - Branch (ex_branch_taken=1): if_id_flush=1, id_ex_flush=1, pc_wr_en=1, if_id_wr_en=1. No scoreboard insert and no MDU start from the squashed ID instruction. In-flight scoreboard entries and mdu_cnt are kept, because they belong to older instructions.
  - Stall: pc_wr_en=0, if_id_wr_en=0, id_ex_flush=1, if_id_flush=0. A jump in ID is held and is not flushed while stalled.
  - Jump (id_is_jump=1): if_id_flush=1. All other outputs take their idle values.
  - Idle: pc_wr_en=1, if_id_wr_en=1, both flushes 0.
- **stall_cnt.** Increments by 1 on each cycle with stall=1 and saturates at all-ones.

## Timing
- Control outputs are combinational from the current inputs and registered state, with zero-cycle latency.
- Scoreboard, mdu_cnt and stall_cnt update on the rising clk edge.
- **Reset, while rst_n=0:**
  - Outputs are forced to pc_wr_en=1, if_id_wr_en=1, if_id_flush=0, id_ex_flush=0, mdu_busy=0.
  - stall_cnt reads its registered value until the edge clears it.
  - At the edge: all scoreboard entries are cleared to invalid, mdu_cnt=0 and stall_cnt=0.
  - A reset asserted mid-MDU or mid-stall abandons it. The first cycle after release is idle.
- **Load latency.** A load in ID at cycle t occupies entry k during cycle t+1+k. A dependent instruction stalls exactly LOAD_LAT cycles if it follows the load directly, and LOAD_LAT-d cycles at distance d (none if d ≥ LOAD_LAT).
- **MDU latency.** An MDU op issued at cycle t gives mdu_busy for cycles t+1 .. t+MDU_LAT. A following mfhi/mflo releases in cycle t+MDU_LAT+1.
- **Simultaneous events.** A load-use and an MDU stall together count as one stall cycle. A branch in the same cycle as a stall overrides it and is not counted.

## Test plan
- LOAD_LAT=1: lw $8 then add $9,$8,$8 → one cycle with pc_wr_en=0, if_id_wr_en=0, id_ex_flush=1; stall_cnt=1.
- LOAD_LAT=3: lw $8, nop, use $8 → exactly 2 stall cycles. A load to $0 followed by a use of $0 → no stall.
- MDU_LAT=4: mult issued at cycle 10, mflo in ID at cycle 11 → stalled on cycles 11–14, advances on cycle 15; mdu_busy low from cycle 15.
- ex_branch_taken=1 during a load-use stall → if_id_flush=1, id_ex_flush=1, pc_wr_en=1, stall_cnt unchanged. A squashed lw in ID creates no entry, so the next cycle shows no load_use.
- jr in ID with a load-use on its rs → no if_id_flush while stalled. On the following cycle: if_id_flush=1, pc_wr_en=1.
- rst_n=0 for one cycle while mdu_cnt=20 and stall_cnt=7 → after release mdu_busy=0, stall_cnt=0, all outputs idle. CNT_W=4 with 20 stall cycles → stall_cnt saturates at 15.
